lsu_tracker: RTL and testbench

Downstream companion to the instruction-fetch tracker. Consumes the load/store instruction records emitted by the fetch tracker, observes the core's data-memory handshake (req/gnt/rvalid), and pairs each completed data transaction with its originating instruction. It emits one timestamped memory-trace record per data access to the trace buffer/output stage.

---
 rtl/gouram_trace_pkg.sv | 48 ++++
 rtl/trace_fifo.sv | 68 ++++++
 rtl/lsu_tracker.sv | 196 +++++++++++++++++++
 tb/tb_lsu_tracker.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gouram_trace_pkg.sv
// Shared trace definitions: the memory-trace record, the LSU handshake
// states, and opcode classifiers also used by the instruction-fetch tracker.
package gouram_trace_pkg;

    localparam int TRACE_ADDR_W = 16;
    localparam int TRACE_DATA_W = 32;
    localparam int TS_W         = 32;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_GNT,
        WAIT_RVALID
    } lsu_state_t;

    // One completed data access paired with its originating instruction
    typedef struct packed {
        logic [TRACE_DATA_W-1:0] instruction;
        logic [TRACE_ADDR_W-1:0] instr_addr;
        logic [TS_W-1:0]         dec_end;
        logic [TRACE_ADDR_W-1:0] data_addr;
        logic                    we;
        logic [TS_W-1:0]         req_time;
        logic [TS_W-1:0]         gnt_time;
        logic [TS_W-1:0]         rvalid_time;
        logic                    orphan;
    } lsu_trace_format;

    function automatic logic is_load(input logic [31:0] instr);
        return instr[6:0] == OPC_LOAD;
    endfunction

    function automatic logic is_store(input logic [31:0] instr);
        return instr[6:0] == OPC_STORE;
    endfunction

    function automatic logic is_branch(input logic [31:0] instr);
        return instr[6:0] == OPC_BRANCH;
    endfunction

    function automatic logic is_load_store(input logic [31:0] instr);
        return is_load(instr) || is_store(instr);
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// Small synchronous FIFO with a combinational head read so the consumer can
// pop and use the head entry in the same cycle. A push into a full FIFO is
// accepted only if a pop happens in that cycle; otherwise it is dropped and
// reported on the drop strobe.
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       drop
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign count    = count_reg;
    assign pop_data = mem[rd_ptr_reg];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;

    // Storage: written only on an accepted push, no reset needed
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap since DEPTH is a power of two
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_W'(1);
                2'b01:   count_reg <= count_reg - CNT_W'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/lsu_tracker.sv
// Load/store tracker: queues load/store instruction records from the fetch
// tracker, follows the data-memory req/gnt/rvalid handshake (one outstanding
// access), and emits one timestamped trace record per completed access.
module lsu_tracker
    import gouram_trace_pkg::*;
#(
    parameter int ADDR_WIDTH       = 16,
    parameter int DATA_WIDTH       = 32,
    parameter int INSTR_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           counter,
    input  logic                  if_data_ready,
    input  logic [DATA_WIDTH-1:0] if_instruction,
    input  logic [ADDR_WIDTH-1:0] if_instr_addr,
    input  logic [31:0]           dec_stage_end,
    input  logic                  data_req,
    input  logic                  data_gnt,
    input  logic                  data_rvalid,
    input  logic                  data_we,
    input  logic [ADDR_WIDTH-1:0] data_addr,
    input  logic                  trace_ready,
    output logic                  trace_valid,
    output logic [DATA_WIDTH-1:0] trace_instruction,
    output logic [ADDR_WIDTH-1:0] trace_instr_addr,
    output logic [31:0]           trace_dec_end,
    output logic [ADDR_WIDTH-1:0] trace_data_addr,
    output logic                  trace_we,
    output logic [31:0]           trace_req_time,
    output logic [31:0]           trace_gnt_time,
    output logic [31:0]           trace_rvalid_time,
    output logic                  trace_orphan,
    output logic                  overflow,
    output logic [15:0]           drop_count
);

    localparam int ENTRY_W = DATA_WIDTH + ADDR_WIDTH + 32;

    // Instruction queue
    logic [ENTRY_W-1:0]              fifo_head;
    logic                            fifo_full_unused;
    logic                            fifo_empty;
    logic [$clog2(INSTR_FIFO_DEPTH):0] fifo_level_unused;
    logic                            fifo_drop;

    // Handshake capture
    lsu_state_t            state_reg, state_next;
    logic [31:0]           req_time_reg, req_time_next;
    logic [31:0]           gnt_time_reg, gnt_time_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  we_reg, we_next;
    logic                  complete;

    // Output record and drop accounting
    lsu_trace_format out_reg, rec_next;
    logic            valid_reg, valid_next;
    logic            load_out;
    logic            out_drop;
    logic            overflow_reg, overflow_next;
    logic [15:0]     drop_count_reg, drop_count_next;
    logic [16:0]     drop_sum;

    assign complete = (state_reg == WAIT_RVALID) && data_rvalid;

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (INSTR_FIFO_DEPTH)
    ) u_instr_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (if_data_ready),
        .push_data ({if_instruction, if_instr_addr, dec_stage_end}),
        .pop       (complete),
        .pop_data  (fifo_head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_level_unused),
        .drop      (fifo_drop)
    );

    // Handshake state register and captured request/grant fields
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            req_time_reg <= '0;
            gnt_time_reg <= '0;
            addr_reg     <= '0;
            we_reg       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            req_time_reg <= req_time_next;
            gnt_time_reg <= gnt_time_next;
            addr_reg     <= addr_next;
            we_reg       <= we_next;
        end
    end

    // Next-state logic; a response with a new request pending restarts capture at once
    always_comb begin
        state_next    = state_reg;
        req_time_next = req_time_reg;
        gnt_time_next = gnt_time_reg;
        addr_next     = addr_reg;
        we_next       = we_reg;
        case (state_reg)
            IDLE, WAIT_RVALID: begin
                if (state_reg == IDLE || data_rvalid) begin
                    state_next = IDLE;
                    if (data_req) begin
                        req_time_next = counter;
                        if (data_gnt) begin
                            gnt_time_next = counter;
                            addr_next     = data_addr;
                            we_next       = data_we;
                            state_next    = WAIT_RVALID;
                        end else begin
                            state_next = WAIT_GNT;
                        end
                    end
                end
            end
            WAIT_GNT: begin
                if (data_gnt) begin
                    gnt_time_next = counter;
                    addr_next     = data_addr;
                    we_next       = data_we;
                    state_next    = WAIT_RVALID;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Merge the completing access with the queue head (zero fields when none is pending)
    always_comb begin
        rec_next             = '0;
        rec_next.data_addr   = TRACE_ADDR_W'(addr_reg);
        rec_next.we          = we_reg;
        rec_next.req_time    = req_time_reg;
        rec_next.gnt_time    = gnt_time_reg;
        rec_next.rvalid_time = counter;
        rec_next.orphan      = fifo_empty;
        if (!fifo_empty) begin
            rec_next.instruction = TRACE_DATA_W'(fifo_head[ENTRY_W-1 -: DATA_WIDTH]);
            rec_next.instr_addr  = TRACE_ADDR_W'(fifo_head[32 +: ADDR_WIDTH]);
            rec_next.dec_end     = fifo_head[31:0];
        end
    end

    // Output slot: load when empty or draining, otherwise the new record is lost
    always_comb begin
        load_out   = complete && (!valid_reg || trace_ready);
        out_drop   = complete && valid_reg && !trace_ready;
        valid_next = valid_reg;
        if (load_out) begin
            valid_next = 1'b1;
        end else if (valid_reg && trace_ready) begin
            valid_next = 1'b0;
        end
        overflow_next   = overflow_reg | fifo_drop | out_drop;
        drop_sum        = {1'b0, drop_count_reg} + 17'(fifo_drop) + 17'(out_drop);
        drop_count_next = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Output record register and sticky drop status
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_reg        <= '0;
            valid_reg      <= 1'b0;
            overflow_reg   <= 1'b0;
            drop_count_reg <= '0;
        end else begin
            if (load_out) begin
                out_reg <= rec_next;
            end
            valid_reg      <= valid_next;
            overflow_reg   <= overflow_next;
            drop_count_reg <= drop_count_next;
        end
    end

    assign trace_valid       = valid_reg;
    assign trace_instruction = DATA_WIDTH'(out_reg.instruction);
    assign trace_instr_addr  = ADDR_WIDTH'(out_reg.instr_addr);
    assign trace_dec_end     = out_reg.dec_end;
    assign trace_data_addr   = ADDR_WIDTH'(out_reg.data_addr);
    assign trace_we          = out_reg.we;
    assign trace_req_time    = out_reg.req_time;
    assign trace_gnt_time    = out_reg.gnt_time;
    assign trace_rvalid_time = out_reg.rvalid_time;
    assign trace_orphan      = out_reg.orphan;
    assign overflow          = overflow_reg;
    assign drop_count        = drop_count_reg;

endmodule

// File: tb/tb_lsu_tracker.sv
// Directed bench for lsu_tracker: a per-cycle vector table for the basic
// pairing paths, then hand-written sequences for overflow, backpressure and
// reset during an outstanding access.
module tb_lsu_tracker;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] counter = '0;
    logic        if_data_ready = 1'b0;
    logic [31:0] if_instruction = '0;
    logic [15:0] if_instr_addr = '0;
    logic [31:0] dec_stage_end = '0;
    logic        data_req = 1'b0;
    logic        data_gnt = 1'b0;
    logic        data_rvalid = 1'b0;
    logic        data_we = 1'b0;
    logic [15:0] data_addr = '0;
    logic        trace_ready = 1'b0;
    logic        trace_valid;
    logic [31:0] trace_instruction;
    logic [15:0] trace_instr_addr;
    logic [31:0] trace_dec_end;
    logic [15:0] trace_data_addr;
    logic        trace_we;
    logic [31:0] trace_req_time;
    logic [31:0] trace_gnt_time;
    logic [31:0] trace_rvalid_time;
    logic        trace_orphan;
    logic        overflow;
    logic [15:0] drop_count;

    int n_cmp  = 0;
    int n_fail = 0;

    lsu_tracker #(
        .ADDR_WIDTH       (16),
        .DATA_WIDTH       (32),
        .INSTR_FIFO_DEPTH (4)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .counter           (counter),
        .if_data_ready     (if_data_ready),
        .if_instruction    (if_instruction),
        .if_instr_addr     (if_instr_addr),
        .dec_stage_end     (dec_stage_end),
        .data_req          (data_req),
        .data_gnt          (data_gnt),
        .data_rvalid       (data_rvalid),
        .data_we           (data_we),
        .data_addr         (data_addr),
        .trace_ready       (trace_ready),
        .trace_valid       (trace_valid),
        .trace_instruction (trace_instruction),
        .trace_instr_addr  (trace_instr_addr),
        .trace_dec_end     (trace_dec_end),
        .trace_data_addr   (trace_data_addr),
        .trace_we          (trace_we),
        .trace_req_time    (trace_req_time),
        .trace_gnt_time    (trace_gnt_time),
        .trace_rvalid_time (trace_rvalid_time),
        .trace_orphan      (trace_orphan),
        .overflow          (overflow),
        .drop_count        (drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        ifr;
        logic [31:0] instr;
        logic [15:0] iaddr;
        logic [31:0] dec;
        logic        req;
        logic        gnt;
        logic        rv;
        logic        we;
        logic [15:0] daddr;
        logic        rdy;
        logic [31:0] cnt;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [15:0] e_iaddr;
        logic [31:0] e_dec;
        logic [15:0] e_daddr;
        logic        e_we;
        logic [31:0] e_req;
        logic [31:0] e_gnt;
        logic [31:0] e_rv;
        logic        e_orphan;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        counter = counter + 1;
    endtask

    task automatic idle_inputs();
        if_data_ready = 1'b0;
        data_req      = 1'b0;
        data_gnt      = 1'b0;
        data_rvalid   = 1'b0;
        data_we       = 1'b0;
        data_addr     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("reset_valid", 32'(trace_valid), 32'd0);
        chk("reset_overflow", 32'(overflow), 32'd0);
        chk("reset_drop", 32'(drop_count), 32'd0);
        chk("reset_req_time", trace_req_time, 32'd0);
        do_reset();

        // ---------------- table-driven vectors ----------------
        // single load
        tbl.push_back('{1, 32'h00412083, 16'h0040, 10, 0,0,0,0, 16'h0000, 0, 10, 0, 0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0, 0, 0, 0, 1,0,0,0, 16'h0000, 0, 20, 0, 0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0, 0, 0, 0, 1,1,0,0, 16'h0100, 0, 22, 0, 0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0, 0, 0, 0, 0,0,1,0, 16'h0000, 0, 25, 1, 32'h00412083,16'h0040,10,16'h0100,0,20,22,25,0});
        tbl.push_back('{0, 0, 0, 0, 0,0,0,0, 16'h0000, 1, 26, 0, 0,0,0,0,0,0,0,0,0});
        // req/gnt same cycle, response with a new request in the same cycle
        tbl.push_back('{1, 32'h00812103, 16'h0044, 28, 0,0,0,0, 16'h0000, 1, 28, 0, 0,0,0,0,0,0,0,0,0});
        tbl.push_back('{1, 32'h00c12183, 16'h0048, 29, 1,1,0,1, 16'h0200, 1, 30, 0, 0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0, 0, 0, 0, 1,1,1,0, 16'h0204, 1, 31, 1, 32'h00812103,16'h0044,28,16'h0200,1,30,30,31,0});
        tbl.push_back('{0, 0, 0, 0, 0,0,1,0, 16'h0000, 1, 32, 1, 32'h00c12183,16'h0048,29,16'h0204,0,31,31,32,0});
        tbl.push_back('{0, 0, 0, 0, 0,0,0,0, 16'h0000, 1, 33, 0, 0,0,0,0,0,0,0,0,0});
        // orphan: no pending instruction
        tbl.push_back('{0, 0, 0, 0, 1,1,0,0, 16'h0300, 0, 40, 0, 0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0, 0, 0, 0, 0,0,1,0, 16'h0000, 0, 41, 1, 0,0,0,16'h0300,0,40,40,41,1});
        tbl.push_back('{0, 0, 0, 0, 0,0,0,0, 16'h0000, 1, 42, 0, 0,0,0,0,0,0,0,0,0});
        // grant/response while idle are ignored
        tbl.push_back('{0, 0, 0, 0, 0,1,1,0, 16'h0000, 1, 50, 0, 0,0,0,0,0,0,0,0,0});
        tbl.push_back('{0, 0, 0, 0, 0,0,1,0, 16'h0000, 1, 51, 0, 0,0,0,0,0,0,0,0,0});

        for (int i = 0; i < tbl.size(); i++) begin
            if_data_ready  = tbl[i].ifr;
            if_instruction = tbl[i].instr;
            if_instr_addr  = tbl[i].iaddr;
            dec_stage_end  = tbl[i].dec;
            data_req       = tbl[i].req;
            data_gnt       = tbl[i].gnt;
            data_rvalid    = tbl[i].rv;
            data_we        = tbl[i].we;
            data_addr      = tbl[i].daddr;
            trace_ready    = tbl[i].rdy;
            counter        = tbl[i].cnt;
            cyc();
            chk($sformatf("v%0d_valid", i), 32'(trace_valid), 32'(tbl[i].e_valid));
            chk($sformatf("v%0d_overflow", i), 32'(overflow), 32'd0);
            if (tbl[i].e_valid) begin
                chk($sformatf("v%0d_instr", i), trace_instruction, tbl[i].e_instr);
                chk($sformatf("v%0d_iaddr", i), 32'(trace_instr_addr), 32'(tbl[i].e_iaddr));
                chk($sformatf("v%0d_dec", i), trace_dec_end, tbl[i].e_dec);
                chk($sformatf("v%0d_daddr", i), 32'(trace_data_addr), 32'(tbl[i].e_daddr));
                chk($sformatf("v%0d_we", i), 32'(trace_we), 32'(tbl[i].e_we));
                chk($sformatf("v%0d_req", i), trace_req_time, tbl[i].e_req);
                chk($sformatf("v%0d_gnt", i), trace_gnt_time, tbl[i].e_gnt);
                chk($sformatf("v%0d_rv", i), trace_rvalid_time, tbl[i].e_rv);
                chk($sformatf("v%0d_orphan", i), 32'(trace_orphan), 32'(tbl[i].e_orphan));
            end
        end
        idle_inputs();

        // ---------------- instruction FIFO overflow ----------------
        do_reset();
        trace_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if_data_ready  = 1'b1;
            if_instruction = 32'hA000_0000 + 32'(k);
            if_instr_addr  = 16'(k * 4);
            dec_stage_end  = 32'(100 + k);
            cyc();
            if (k == 3) chk("ovf_before_full", 32'(overflow), 32'd0);
        end
        if_data_ready = 1'b0;
        chk("ovf_flag", 32'(overflow), 32'd1);
        chk("ovf_drop_count", 32'(drop_count), 32'd1);
        for (int k = 0; k < 4; k++) begin
            data_req = 1'b1;
            data_gnt = 1'b1;
            cyc();
            data_req    = 1'b0;
            data_gnt    = 1'b0;
            data_rvalid = 1'b1;
            // push into the full queue while it pops: must not count as a drop
            if (k == 0) begin
                if_data_ready  = 1'b1;
                if_instruction = 32'hA000_0005;
            end
            cyc();
            data_rvalid   = 1'b0;
            if_data_ready = 1'b0;
            chk($sformatf("ovf_pop%0d_valid", k), 32'(trace_valid), 32'd1);
            chk($sformatf("ovf_pop%0d_instr", k), trace_instruction, 32'hA000_0000 + 32'(k));
            chk($sformatf("ovf_pop%0d_dec", k), trace_dec_end, 32'(100 + k));
            chk($sformatf("ovf_pop%0d_drop", k), 32'(drop_count), 32'd1);
        end

        // ---------------- output backpressure ----------------
        do_reset();
        trace_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            data_req = 1'b1;
            data_gnt = 1'b1;
            counter  = 32'(200 + 10 * k);
            cyc();
            data_req    = 1'b0;
            data_gnt    = 1'b0;
            data_rvalid = 1'b1;
            counter     = 32'(201 + 10 * k);
            cyc();
            data_rvalid = 1'b0;
        end
        chk("bp_valid_held", 32'(trace_valid), 32'd1);
        chk("bp_first_kept", trace_rvalid_time, 32'd201);
        chk("bp_orphan", 32'(trace_orphan), 32'd1);
        chk("bp_drop_count", 32'(drop_count), 32'd1);
        chk("bp_overflow", 32'(overflow), 32'd1);
        trace_ready = 1'b1;
        cyc();
        chk("bp_drained", 32'(trace_valid), 32'd0);

        // ---------------- reset while waiting for a response ----------------
        trace_ready = 1'b0;
        data_req    = 1'b1;
        data_gnt    = 1'b1;
        cyc();
        data_req    = 1'b0;
        data_gnt    = 1'b0;
        data_rvalid = 1'b1;
        cyc();
        data_rvalid = 1'b0;
        chk("rst_pre_valid", 32'(trace_valid), 32'd1);
        data_req = 1'b1;
        data_gnt = 1'b1;
        cyc();
        idle_inputs();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid", 32'(trace_valid), 32'd0);
        chk("rst_async_overflow", 32'(overflow), 32'd0);
        chk("rst_async_drop", 32'(drop_count), 32'd0);
        chk("rst_async_req_time", trace_req_time, 32'd0);
        cyc();
        rst_n = 1'b1;
        cyc();
        trace_ready = 1'b1;
        data_rvalid = 1'b1;
        cyc();
        chk("rst_stray_rvalid", 32'(trace_valid), 32'd0);
        cyc();
        data_rvalid = 1'b0;
        chk("rst_stray_rvalid2", 32'(trace_valid), 32'd0);
        chk("rst_final_overflow", 32'(overflow), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
